// File: rtl/key_event_encoder.sv
// Key event encoder: turns debounced key levels into a queue of
// press/release events. Edges are detected per key, held as pending bits
// (with press/release pairs cancelling each other), serialized by fixed
// priority (releases first, lowest index first) and pushed into a small
// FIFO whose head is decoded to a one-hot key number.
module key_event_encoder #(
  parameter int DEPTH = 4,
  parameter int NKEYS = 17
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [NKEYS-1:0] keys_in,
  input  logic             note_ack,
  output logic             note_ready,
  output logic [NKEYS-1:0] key_num,
  output logic             note_on,
  output logic [2:0]       count
);

  localparam int         PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [2:0] DEPTH_C = 3'(DEPTH);

  // Edge detection and pending-event state
  logic [NKEYS-1:0] prev_reg;
  logic [NKEYS-1:0] pend_press_reg;
  logic [NKEYS-1:0] pend_release_reg;
  logic [NKEYS-1:0] pend_press_next;
  logic [NKEYS-1:0] pend_release_next;
  logic [NKEYS-1:0] rise;
  logic [NKEYS-1:0] fall;

  // Selection of the event to push this cycle
  logic             sel_valid;
  logic             sel_press;
  logic [4:0]       sel_idx;
  logic [NKEYS-1:0] sel_onehot;
  logic [NKEYS-1:0] clr_press;
  logic [NKEYS-1:0] clr_release;
  logic [NKEYS-1:0] press_kept;
  logic [NKEYS-1:0] release_kept;

  // Event FIFO: each entry is {note_on, key index}
  logic [5:0]       mem [DEPTH];
  logic [PW-1:0]    rd_ptr_reg;
  logic [PW-1:0]    wr_ptr_reg;
  logic [2:0]       count_reg;
  logic [5:0]       head;
  logic             push;
  logic             pop;

  assign rise = keys_in & ~prev_reg;
  assign fall = ~keys_in & prev_reg;

  // Fixed-priority pick: scanning downwards lets the lowest index win, and the
  // release scan runs last so any pending release beats every pending press.
  always_comb begin
    sel_valid = 1'b0;
    sel_press = 1'b0;
    sel_idx   = 5'd0;
    for (int i = NKEYS - 1; i >= 0; i--) begin
      if (pend_press_reg[i]) begin
        sel_valid = 1'b1;
        sel_press = 1'b1;
        sel_idx   = 5'(i);
      end
    end
    for (int i = NKEYS - 1; i >= 0; i--) begin
      if (pend_release_reg[i]) begin
        sel_valid = 1'b1;
        sel_press = 1'b0;
        sel_idx   = 5'(i);
      end
    end
  end

  assign pop  = note_ready & note_ack;
  // A full FIFO still accepts a push when the head leaves on the same edge.
  assign push = sel_valid & ((count_reg < DEPTH_C) | pop);

  assign clr_press    = (push &  sel_press) ? sel_onehot : '0;
  assign clr_release  = (push & ~sel_press) ? sel_onehot : '0;
  // Only bits that were already pending are cleared by a push, so bits set
  // by this cycle's edges become selectable on the next cycle.
  assign press_kept   = pend_press_reg & ~clr_press;
  assign release_kept = pend_release_reg & ~clr_release;

  // Per-key pending update. The push clear is applied first, so an edge
  // arriving while its opposite event is being pushed becomes a new event
  // instead of cancelling one that is already in the FIFO.
  generate
    for (genvar gi = 0; gi < NKEYS; gi++) begin : g_key
      assign sel_onehot[gi] = (sel_idx == 5'(gi));
      assign pend_press_next[gi] = rise[gi] ? ~release_kept[gi] :
                                   fall[gi] ? 1'b0 : press_kept[gi];
      assign pend_release_next[gi] = fall[gi] ? ~press_kept[gi] :
                                     rise[gi] ? 1'b0 : release_kept[gi];
      assign key_num[gi] = note_ready & (head[4:0] == 5'(gi));
    end
  endgenerate

  // Key history, pending bits, FIFO pointers and occupancy
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      prev_reg         <= '0;
      pend_press_reg   <= '0;
      pend_release_reg <= '0;
      rd_ptr_reg       <= '0;
      wr_ptr_reg       <= '0;
      count_reg        <= 3'd0;
    end else begin
      prev_reg         <= keys_in;
      pend_press_reg   <= pend_press_next;
      pend_release_reg <= pend_release_next;
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PW'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PW'(1);
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 3'd1;
        2'b01:   count_reg <= count_reg - 3'd1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  // FIFO storage write; contents need no reset because the head is gated by occupancy
  always_ff @(posedge clock) begin
    if (push) begin
      mem[wr_ptr_reg] <= {sel_press, sel_idx};
    end
  end

  assign head       = mem[rd_ptr_reg];
  assign note_ready = (count_reg != 3'd0);
  assign note_on    = note_ready & head[5];
  assign count      = count_reg;

endmodule
